stack_spill_ctrl: RTL and testbench

Controller for the data stack. It executes the 3-bit stack action codes issued by the control unit on an on-chip register ring of DEPTH entries. It spills the bottom entry to memory when the ring is full and refills from memory when fewer than two entries remain cached. It sits between the control unit (action/handshake) and the memory port, so the whole stack appears unbounded to the datapath up to DEPTH+MAX_SPILL entries.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_ring.sv | 62 ++++++
 rtl/stack_spill_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_stack_spill_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the data stack.
// Holds the 3-bit stack action codes issued by the control unit and the
// state encoding of the spill/fill controller FSM.
package stack_pkg;

  localparam logic [2:0] ACT_NOP     = 3'b000;
  localparam logic [2:0] ACT_POP     = 3'b001;
  localparam logic [2:0] ACT_DROP    = 3'b010;
  localparam logic [2:0] ACT_REPLACE = 3'b011;
  localparam logic [2:0] ACT_PUSH    = 3'b100;
  localparam logic [2:0] ACT_DUP     = 3'b101;
  localparam logic [2:0] ACT_RSVD    = 3'b110;
  localparam logic [2:0] ACT_SWAP    = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

endpackage

// File: rtl/stack_ring.sv
// Register ring holding the cached part of the data stack.
// Ports:
//   clk_i        clock, rising edge
//   top_i        ring index of the top-of-stack entry
//   bot_i        ring index of the bottom cached entry
//   push_i       write wdata_i at top_i+1
//   repl_i       write wdata_i at top_i
//   swap_i       exchange entries top_i and top_i-1
//   fill_i       write fill_data_i at bot_i-1 (entry refilled from memory)
//   wdata_i      data for push/replace
//   fill_data_i  data returned by a memory fill
//   tos_o/nos_o  raw ring[top], ring[top-1]
//   bot_o        raw ring[bottom], the candidate for spilling
// Contents are not reset; the controller masks reads by the cached count.
module stack_ring #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [IW-1:0]    top_i,
  input  logic [IW-1:0]    bot_i,
  input  logic             push_i,
  input  logic             repl_i,
  input  logic             swap_i,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] fill_data_i,
  output logic [WIDTH-1:0] tos_o,
  output logic [WIDTH-1:0] nos_o,
  output logic [WIDTH-1:0] bot_o
);

  logic [WIDTH-1:0] ring_q [DEPTH];
  logic [IW-1:0]    top_up;
  logic [IW-1:0]    top_dn;
  logic [IW-1:0]    bot_dn;

  // Index arithmetic wraps naturally in IW bits since DEPTH is a power of 2.
  assign top_up = top_i + IW'(1);
  assign top_dn = top_i - IW'(1);
  assign bot_dn = bot_i - IW'(1);

  assign tos_o = ring_q[top_i];
  assign nos_o = ring_q[top_dn];
  assign bot_o = ring_q[bot_i];

  // The controller guarantees at most one write request per cycle.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      ring_q[top_up] <= wdata_i;
    end else if (repl_i) begin
      ring_q[top_i] <= wdata_i;
    end else if (swap_i) begin
      ring_q[top_i]  <= ring_q[top_dn];
      ring_q[top_dn] <= ring_q[top_i];
    end else if (fill_i) begin
      ring_q[bot_dn] <= fill_data_i;
    end
  end

endmodule

// File: rtl/stack_spill_ctrl.sv
// Data stack controller: executes stack actions on a DEPTH-entry register
// ring, spilling the bottom entry to memory when the ring is full and
// refilling from memory when fewer than two entries remain cached.
// Ports:
//   CLK, Reset           clock and synchronous active-high reset
//   action, action_valid, action_ready   action handshake with control unit
//   din                  data for PUSH/REPLACE
//   tos, nos             top / next on stack (0 when not cached)
//   depth                cached + spilled entries
//   underflow, overflow  one-cycle pulses after a rejected action
//   mem_req/we/addr/wdata/rdata/ack   spill/fill memory port
module stack_spill_ctrl
  import stack_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          DEPTH      = 8,
  parameter int          MAX_SPILL  = 256,
  parameter logic [15:0] SPILL_BASE = 16'hF000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [2:0]       action,
  input  logic             action_valid,
  output logic             action_ready,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [15:0]      depth,
  output logic             underflow,
  output logic             overflow,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = IW + 1;
  localparam int SPW = $clog2(MAX_SPILL + 1);

  state_e           state_q;
  logic [IW-1:0]    t_q;
  logic [CW-1:0]    cnt_q;
  logic [SPW-1:0]   sp_q;
  logic             uf_q;
  logic             of_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [15:0]      mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;

  logic             full, has1, has2, sp_full, sp_any;
  logic             fill_pending, spill_need, accept, fill_we;
  logic             do_push, do_dup, do_pop, do_repl, do_swap, lack, ovf;
  logic [IW-1:0]    bot;
  logic [WIDTH-1:0] tos_raw, nos_raw, bot_raw, ring_wdata;

  assign full    = (cnt_q == CW'(DEPTH));
  assign has1    = (cnt_q != '0);
  assign has2    = (cnt_q >= CW'(2));
  assign sp_full = (sp_q == SPW'(MAX_SPILL));
  assign sp_any  = (sp_q != '0);

  // Refill has priority over any presented action.
  assign fill_pending = !has2 && sp_any;
  // A growing action on a full ring is held until the bottom entry is spilled;
  // once memory is exhausted it is accepted instead and reported as overflow.
  assign spill_need   = action_valid && (action == ACT_PUSH || action == ACT_DUP)
                        && full && !sp_full;
  assign action_ready = (state_q == ST_IDLE) && !fill_pending && !spill_need;
  assign accept       = action_valid && action_ready;
  assign fill_we      = (state_q == ST_FILL) && mem_ack;

  // Bottom = t - cnt + 1; with cnt == DEPTH the truncated count is 0.
  assign bot = t_q - IW'(cnt_q) + IW'(1);

  always_comb begin
    do_push = 1'b0;
    do_dup  = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    do_swap = 1'b0;
    lack    = 1'b0;
    ovf     = 1'b0;
    if (accept) begin
      case (action)
        ACT_POP, ACT_DROP: if (has1) do_pop = 1'b1; else lack = 1'b1;
        ACT_REPLACE:       if (has1) do_repl = 1'b1; else lack = 1'b1;
        ACT_PUSH:          if (full) ovf = 1'b1; else do_push = 1'b1;
        ACT_DUP: begin
          if (!has1)     lack   = 1'b1;
          else if (full) ovf    = 1'b1;
          else           do_dup = 1'b1;
        end
        ACT_SWAP:          if (has2) do_swap = 1'b1; else lack = 1'b1;
        default: ;
      endcase
    end
  end

  assign ring_wdata = do_dup ? tos_raw : din;

  stack_ring #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ring (
    .clk_i       (CLK),
    .top_i       (t_q),
    .bot_i       (bot),
    .push_i      (do_push || do_dup),
    .repl_i      (do_repl),
    .swap_i      (do_swap),
    .fill_i      (fill_we),
    .wdata_i     (ring_wdata),
    .fill_data_i (mem_rdata),
    .tos_o       (tos_raw),
    .nos_o       (nos_raw),
    .bot_o       (bot_raw)
  );

  // Controller FSM, counters and memory handshake registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      t_q         <= IW'(DEPTH - 1);
      cnt_q       <= '0;
      sp_q        <= '0;
      uf_q        <= 1'b0;
      of_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      uf_q <= lack;
      of_q <= ovf;
      case (state_q)
        ST_IDLE: begin
          if (fill_pending) begin
            state_q    <= ST_FILL;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= SPILL_BASE + 16'(sp_q) - 16'd1;
          end else if (spill_need) begin
            state_q     <= ST_SPILL;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= SPILL_BASE + 16'(sp_q);
            mem_wdata_q <= bot_raw;
          end else if (do_push || do_dup) begin
            t_q   <= t_q + IW'(1);
            cnt_q <= cnt_q + CW'(1);
          end else if (do_pop) begin
            t_q   <= t_q - IW'(1);
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_SPILL: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            sp_q      <= sp_q + SPW'(1);
            cnt_q     <= cnt_q - CW'(1);
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            sp_q      <= sp_q - SPW'(1);
            cnt_q     <= cnt_q + CW'(1);
            mem_req_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tos       = has1 ? tos_raw : '0;
  assign nos       = has2 ? nos_raw : '0;
  assign depth     = 16'(cnt_q) + 16'(sp_q);
  assign underflow = uf_q;
  assign overflow  = of_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_stack_spill_ctrl.sv
module tb_stack_spill_ctrl;

  logic        CLK;
  logic        Reset;
  logic [2:0]  action;
  logic        action_valid;
  logic        action_ready;
  logic [15:0] din;
  logic [15:0] tos;
  logic [15:0] nos;
  logic [15:0] depth;
  logic        underflow;
  logic        overflow;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int n_pass;
  int n_total;

  logic [15:0] mem_model [4];
  logic [15:0] fill_log [$];
  bit          auto_ack;
  bit          ack_now;
  logic [15:0] pt;

  localparam logic [2:0] POP = 3'b001, DROP = 3'b010, REPL = 3'b011,
                         PUSH = 3'b100, DUP = 3'b101, RSVD = 3'b110, SWAP = 3'b111;

  stack_spill_ctrl #(
    .WIDTH      (16),
    .DEPTH      (4),
    .MAX_SPILL  (2),
    .SPILL_BASE (16'hF000)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .action       (action),
    .action_valid (action_valid),
    .action_ready (action_ready),
    .din          (din),
    .tos          (tos),
    .nos          (nos),
    .depth        (depth),
    .underflow    (underflow),
    .overflow     (overflow),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory responder: auto mode acks two negedges after a request,
  // manual mode acks on ack_now (even with no request, for the late-ack case).
  task automatic serve();
    if (mem_req) begin
      if (mem_we) mem_model[mem_addr[1:0]] = mem_wdata;
      else begin
        mem_rdata = mem_model[mem_addr[1:0]];
        fill_log.push_back(mem_addr);
      end
    end
    mem_ack = 1'b1;
  endtask

  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (mem_ack) mem_ack = 1'b0;
      else if (auto_ack && mem_req) begin
        wcnt++;
        if (wcnt >= 2) begin
          wcnt = 0;
          serve();
        end
      end else if (ack_now) serve();
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    Reset = 1'b1;
    action_valid = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  // Presents one action, waits (bounded) for acceptance, returns the tos seen
  // just before the accepting edge. Returns 1 ns after that edge.
  task automatic issue(input logic [2:0] a, input logic [15:0] d, output logic [15:0] pre_tos);
    int g;
    g = 0;
    @(negedge CLK);
    action = a;
    din = d;
    action_valid = 1'b1;
    #1;
    while (!action_ready && g < 200) begin
      @(negedge CLK);
      #1;
      g++;
    end
    n_total++;
    if (!action_ready) $display("FAIL issue_timeout: action %0d ready=%0b required 1", a, action_ready);
    else n_pass++;
    pre_tos = tos;
    @(posedge CLK);
    #1;
    action_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++; if (action_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", action_ready); else n_pass++;
    n_total++; if (tos !== 16'd0) $display("FAIL rst_tos: got %0d want 0", tos); else n_pass++;
    n_total++; if (nos !== 16'd0) $display("FAIL rst_nos: got %0d want 0", nos); else n_pass++;
    n_total++; if (depth !== 16'd0) $display("FAIL rst_depth: got %0d want 0", depth); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %0b want 0", mem_req); else n_pass++;
    n_total++; if (underflow !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rst_pulses: got uf=%0b of=%0b want 0 0", underflow, overflow); else n_pass++;
  endtask

  task automatic test_push();
    for (int i = 1; i <= 3; i++) issue(PUSH, 16'(i), pt);
    n_total++; if (tos !== 16'd3) $display("FAIL push_tos: got %0d want 3", tos); else n_pass++;
    n_total++; if (nos !== 16'd2) $display("FAIL push_nos: got %0d want 2", nos); else n_pass++;
    n_total++; if (depth !== 16'd3) $display("FAIL push_depth: got %0d want 3", depth); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL push_mem_req: got %0b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_spill();
    apply_reset();
    auto_ack = 1'b0;
    for (int i = 1; i <= 4; i++) issue(PUSH, 16'(i), pt);
    @(negedge CLK);
    action = PUSH; din = 16'd5; action_valid = 1'b1;
    #1;
    n_total++; if (action_ready !== 1'b0) $display("FAIL spill_ready: got %0b want 0", action_ready); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (mem_req !== 1'b1) $display("FAIL spill_req: got %0b want 1", mem_req); else n_pass++;
    n_total++; if (mem_we !== 1'b1) $display("FAIL spill_we: got %0b want 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 16'hF000) $display("FAIL spill_addr: got %h want f000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 16'd1) $display("FAIL spill_wdata: got %0d want 1", mem_wdata); else n_pass++;
    ack_now = 1'b1;
    @(posedge CLK); #1;
    ack_now = 1'b0;
    n_total++; if (mem_req !== 1'b0) $display("FAIL spill_req_drop: got %0b want 0", mem_req); else n_pass++;
    n_total++; if (action_ready !== 1'b1) $display("FAIL spill_ready_after: got %0b want 1", action_ready); else n_pass++;
    @(posedge CLK); #1;
    action_valid = 1'b0;
    n_total++; if (tos !== 16'd5) $display("FAIL spill_tos: got %0d want 5", tos); else n_pass++;
    n_total++; if (depth !== 16'd5) $display("FAIL spill_depth: got %0d want 5", depth); else n_pass++;
    auto_ack = 1'b1;
  endtask

  task automatic test_fill();
    int n0;
    issue(PUSH, 16'd6, pt);
    n_total++; if (depth !== 16'd6) $display("FAIL fill_depth6: got %0d want 6", depth); else n_pass++;
    n0 = fill_log.size();
    for (int i = 0; i < 5; i++) begin
      issue(POP, 16'd0, pt);
      n_total++; if (pt !== 16'(6 - i)) $display("FAIL fill_pop%0d: got %0d want %0d", i, pt, 6 - i); else n_pass++;
    end
    n_total++; if (tos !== 16'd1) $display("FAIL fill_final_tos: got %0d want 1", tos); else n_pass++;
    n_total++; if (depth !== 16'd1) $display("FAIL fill_final_depth: got %0d want 1", depth); else n_pass++;
    n_total++;
    if (fill_log.size() - n0 != 2) $display("FAIL fill_count: got %0d want 2", fill_log.size() - n0);
    else if (fill_log[n0] !== 16'hF001 || fill_log[n0+1] !== 16'hF000)
      $display("FAIL fill_addrs: got %h %h want f001 f000", fill_log[n0], fill_log[n0+1]);
    else n_pass++;
  endtask

  task automatic test_underflow();
    apply_reset();
    issue(POP, 16'd0, pt);
    n_total++; if (underflow !== 1'b1) $display("FAIL uf_pop: got %0b want 1", underflow); else n_pass++;
    n_total++; if (depth !== 16'd0) $display("FAIL uf_depth: got %0d want 0", depth); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (underflow !== 1'b0) $display("FAIL uf_pulse_end: got %0b want 0", underflow); else n_pass++;
    issue(PUSH, 16'd7, pt);
    issue(SWAP, 16'd0, pt);
    n_total++; if (underflow !== 1'b1) $display("FAIL uf_swap: got %0b want 1", underflow); else n_pass++;
    n_total++; if (tos !== 16'd7) $display("FAIL uf_swap_tos: got %0d want 7", tos); else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 6; i++) issue(PUSH, 16'(i), pt);
    n_total++; if (depth !== 16'd6) $display("FAIL of_depth_pre: got %0d want 6", depth); else n_pass++;
    issue(PUSH, 16'd9, pt);
    n_total++; if (overflow !== 1'b1) $display("FAIL of_pulse: got %0b want 1", overflow); else n_pass++;
    n_total++; if (depth !== 16'd6) $display("FAIL of_depth: got %0d want 6", depth); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL of_mem_req: got %0b want 0", mem_req); else n_pass++;
    n_total++; if (tos !== 16'd6) $display("FAIL of_tos: got %0d want 6", tos); else n_pass++;
    @(posedge CLK); #1;
    n_total++; if (overflow !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL of_after: got of=%0b req=%0b want 0 0", overflow, mem_req); else n_pass++;
  endtask

  task automatic test_ops();
    apply_reset();
    issue(PUSH, 16'd10, pt);
    issue(PUSH, 16'd20, pt);
    issue(SWAP, 16'd0, pt);
    n_total++; if (tos !== 16'd10 || nos !== 16'd20)
      $display("FAIL ops_swap: got %0d %0d want 10 20", tos, nos); else n_pass++;
    issue(REPL, 16'd30, pt);
    n_total++; if (tos !== 16'd30 || nos !== 16'd20)
      $display("FAIL ops_replace: got %0d %0d want 30 20", tos, nos); else n_pass++;
    issue(DUP, 16'd0, pt);
    n_total++; if (tos !== 16'd30 || nos !== 16'd30 || depth !== 16'd3)
      $display("FAIL ops_dup: got %0d %0d d=%0d want 30 30 d=3", tos, nos, depth); else n_pass++;
    issue(RSVD, 16'd55, pt);
    n_total++; if (tos !== 16'd30 || depth !== 16'd3 || underflow !== 1'b0)
      $display("FAIL ops_rsvd: got %0d d=%0d uf=%0b want 30 d=3 uf=0", tos, depth, underflow); else n_pass++;
    issue(DROP, 16'd0, pt);
    n_total++; if (tos !== 16'd30 || nos !== 16'd20 || depth !== 16'd2)
      $display("FAIL ops_drop: got %0d %0d d=%0d want 30 20 d=2", tos, nos, depth); else n_pass++;
  endtask

  task automatic test_reset_mid_spill();
    apply_reset();
    auto_ack = 1'b0;
    for (int i = 1; i <= 4; i++) issue(PUSH, 16'(i), pt);
    @(negedge CLK);
    action = PUSH; din = 16'd5; action_valid = 1'b1;
    @(posedge CLK); #1;
    n_total++; if (mem_req !== 1'b1) $display("FAIL rms_req: got %0b want 1", mem_req); else n_pass++;
    @(negedge CLK);
    Reset = 1'b1;
    action_valid = 1'b0;
    @(posedge CLK); #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL rms_req_drop: got %0b want 0", mem_req); else n_pass++;
    n_total++; if (depth !== 16'd0) $display("FAIL rms_depth: got %0d want 0", depth); else n_pass++;
    @(negedge CLK);
    Reset = 1'b0;
    @(posedge CLK); #1;
    ack_now = 1'b1;
    @(posedge CLK); #1;
    ack_now = 1'b0;
    @(posedge CLK); #1;
    n_total++; if (mem_req !== 1'b0 || depth !== 16'd0)
      $display("FAIL rms_late_ack: got req=%0b d=%0d want 0 0", mem_req, depth); else n_pass++;
    n_total++; if (action_ready !== 1'b1 || tos !== 16'd0)
      $display("FAIL rms_idle: got ready=%0b tos=%0d want 1 0", action_ready, tos); else n_pass++;
    auto_ack = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    action = '0;
    action_valid = 1'b0;
    din = '0;
    auto_ack = 1'b1;
    ack_now = 1'b0;
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_push();
    test_spill();
    test_fill();
    test_underflow();
    test_overflow();
    test_ops();
    test_reset_mid_spill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
